// File: rtl/feature_map_buffer_reader_if.sv
// rtl/feature_map_buffer_reader_if.sv - buffer RAM read port and output stream bundle
interface feature_map_buffer_reader_if #(
  parameter int ADDR_WIDTH = 7,
  parameter int DATA_WIDTH = 16
);
  logic                  rd_en;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [DATA_WIDTH-1:0] rd_data;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [3:0]            out_xcoord;
  logic [3:0]            out_ycoord;
  logic                  out_last;

  modport master (
    output rd_en, rd_addr, out_data, out_valid, out_xcoord, out_ycoord, out_last,
    input  rd_data, out_ready
  );

  modport slave (
    input  rd_en, rd_addr, out_data, out_valid, out_xcoord, out_ycoord, out_last,
    output rd_data, out_ready
  );
endinterface

// File: rtl/feature_map_buffer_reader.sv
// rtl/feature_map_buffer_reader.sv - frame reader streaming buffer words with x/y tags
module feature_map_buffer_reader #(
  parameter int FM_WIDTH   = 11,
  parameter int FM_HEIGHT  = 11,
  parameter int ADDR_WIDTH = 7,
  parameter int DATA_WIDTH = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic buffer_full,
  output logic busy,
  output logic frame_done,
  output logic overrun,
  feature_map_buffer_reader_if.master bus
);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(FM_WIDTH * FM_HEIGHT - 1);
  localparam logic [3:0]            X_LAST    = 4'(FM_WIDTH - 1);
  localparam int                    EW        = DATA_WIDTH + 9;

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;
  state_t state, state_nx;

  logic                  buffer_full_q, pending, start;
  logic [ADDR_WIDTH-1:0] addr;
  logic [3:0]            ix, iy;
  logic                  inflight;
  logic [8:0]            inflight_tag;
  logic [EW-1:0]         fifo_mem [2];
  logic                  wr_ptr, rd_ptr;
  logic [1:0]            count;
  logic                  push, pop, issue, issue_last, drained;

  assign start      = buffer_full & ~buffer_full_q;
  assign push       = inflight;
  assign pop        = (count != 2'd0) & bus.out_ready;
  // A pop in the same cycle frees a slot, which keeps the stream bubble-free.
  assign issue      = (state == READ) &&
                      (({1'b0, count} + {2'b0, inflight}) < (3'd2 + {2'b0, pop}));
  assign issue_last = issue && (addr == LAST_ADDR);
  assign drained    = !inflight && ((count == 2'd0) || ((count == 2'd1) && pop));

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start || pending) state_nx = READ;
      READ:    if (issue_last) state_nx = DRAIN;
      DRAIN:   if (drained) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      buffer_full_q <= 1'b0;
      pending       <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      state         <= state_nx;
      buffer_full_q <= buffer_full;
      if (state == IDLE) begin
        pending <= 1'b0;
      end else if (start) begin
        if (pending) overrun <= 1'b1;
        else         pending <= 1'b1;
      end
    end
  end

  // Tags travel with the read so the FIFO head carries its own coordinates.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      addr         <= '0;
      ix           <= 4'd0;
      iy           <= 4'd0;
      inflight     <= 1'b0;
      inflight_tag <= 9'd0;
    end else begin
      inflight <= issue;
      if (issue) begin
        inflight_tag <= {issue_last, iy, ix};
        if (issue_last) begin
          addr <= '0;
          ix   <= 4'd0;
          iy   <= 4'd0;
        end else begin
          addr <= addr + 1'b1;
          if (ix == X_LAST) begin
            ix <= 4'd0;
            iy <= iy + 4'd1;
          end else begin
            ix <= ix + 4'd1;
          end
        end
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fifo_mem[0] <= '0;
      fifo_mem[1] <= '0;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      count       <= 2'd0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= {inflight_tag, bus.rd_data};
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign {bus.out_last, bus.out_ycoord, bus.out_xcoord, bus.out_data} = fifo_mem[rd_ptr];
  assign bus.out_valid = (count != 2'd0);
  assign bus.rd_en     = issue;
  assign bus.rd_addr   = addr;
  assign busy          = (state == READ) || (state == DRAIN);
  assign frame_done    = (state == DONE);
endmodule

// File: tb/tb_feature_map_buffer_reader.sv
// tb/tb_feature_map_buffer_reader.sv - scoreboard bench for feature_map_buffer_reader
module tb_feature_map_buffer_reader;
  localparam int NW = 121;

  logic clock, reset, buffer_full, busy, frame_done, overrun;
  feature_map_buffer_reader_if #(.ADDR_WIDTH(7), .DATA_WIDTH(16)) bus();

  feature_map_buffer_reader dut (
    .clock(clock), .reset(reset), .buffer_full(buffer_full),
    .busy(busy), .frame_done(frame_done), .overrun(overrun), .bus(bus)
  );

  typedef struct { logic [15:0] d; logic [3:0] x; logic [3:0] y; logic last; } beat_t;
  typedef struct { int ready_mode; int hold; int extra; int exp_frames; bit exp_overrun; } scen_t;

  logic [15:0] ram [128];
  beat_t       q[$];
  int n_checks = 0, n_fail = 0;
  int ready_mode = 0;
  int exp_addr, issued, xfers_tot, frames_done;
  bit stall_prev, last_xfer_prev, xfer;
  logic [24:0] held;

  task automatic check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic flush();
    q.delete();
    exp_addr = 0; issued = 0; xfers_tot = 0; frames_done = 0;
    stall_prev = 0; last_xfer_prev = 0;
  endtask

  task automatic push_frame();
    beat_t b;
    for (int k = 0; k < NW; k++) begin
      b.d = ram[k]; b.x = 4'(k % 11); b.y = 4'(k / 11); b.last = (k == NW - 1);
      q.push_back(b);
    end
  endtask

  task automatic do_reset();
    reset = 1; buffer_full = 0;
    flush();
    repeat (2) @(posedge clock);
    #1 reset = 0;
    flush();
  endtask

  task automatic wait_frames(input int n, input int limit);
    int cyc = 0;
    while (frames_done < n && cyc < limit) begin
      @(negedge clock);
      cyc++;
    end
    check(cyc < limit, "wait_budget", 64'(cyc), 64'(limit));
  endtask

  initial begin
    clock = 0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) if (bus.rd_en) bus.rd_data <= ram[bus.rd_addr];

  initial begin
    bus.out_ready = 1;
    forever begin
      @(posedge clock);
      #1;
      case (ready_mode)
        0:       bus.out_ready = 1;
        1:       bus.out_ready = 1'($urandom_range(0, 1));
        default: bus.out_ready = ($urandom_range(0, 3) == 0);
      endcase
    end
  end

  // Scoreboard / protocol monitor, sampled away from the active edge.
  always @(negedge clock) begin
    if (!reset) begin
      xfer = bus.out_valid && bus.out_ready;
      if (stall_prev)
        check({bus.out_valid, bus.out_last, bus.out_ycoord, bus.out_xcoord, bus.out_data} == {1'b1, held},
              "stall_hold", 64'({bus.out_last, bus.out_ycoord, bus.out_xcoord, bus.out_data}), 64'(held));
      if (bus.rd_en) begin
        check(bus.rd_addr == 7'(exp_addr), "rd_addr", 64'(bus.rd_addr), 64'(exp_addr));
        exp_addr = (exp_addr == NW - 1) ? 0 : exp_addr + 1;
        check((issued - xfers_tot - (xfer ? 1 : 0)) < 2, "outstanding",
              64'(issued - xfers_tot), 64'(1));
      end
      if (xfer) begin
        if (q.size() == 0) begin
          check(0, "beat_unexpected", 64'(bus.out_data), 64'(0));
        end else begin
          beat_t b;
          b = q.pop_front();
          check(bus.out_data == b.d && bus.out_xcoord == b.x && bus.out_ycoord == b.y && bus.out_last == b.last,
                "beat", 64'({bus.out_last, bus.out_ycoord, bus.out_xcoord, bus.out_data}),
                64'({b.last, b.y, b.x, b.d}));
        end
      end
      if (frame_done) begin
        check(last_xfer_prev, "frame_done_timing", 64'(last_xfer_prev), 64'(1));
        frames_done++;
      end
      last_xfer_prev = xfer && bus.out_last;
      stall_prev     = bus.out_valid && !bus.out_ready;
      held           = {bus.out_last, bus.out_ycoord, bus.out_xcoord, bus.out_data};
      if (bus.rd_en) issued++;
      if (xfer) xfers_tot++;
    end
  end

  initial begin
    scen_t sc [6];
    int first_c, last_c, done_c;
    sc[0] = '{0, 1,   0, 1, 0};
    sc[1] = '{1, 1,   0, 1, 0};
    sc[2] = '{0, 300, 1, 2, 0};
    sc[3] = '{0, 1,   2, 2, 1};
    sc[4] = '{2, 1,   1, 2, 0};
    sc[5] = '{1, 1,   3, 2, 1};
    for (int i = 0; i < 128; i++) ram[i] = 16'($urandom);

    reset = 1; buffer_full = 0;
    flush();
    #2;
    check(bus.rd_en == 0,      "rst_rd_en",      64'(bus.rd_en), 0);
    check(bus.rd_addr == 0,    "rst_rd_addr",    64'(bus.rd_addr), 0);
    check(bus.out_valid == 0,  "rst_out_valid",  64'(bus.out_valid), 0);
    check(bus.out_data == 0,   "rst_out_data",   64'(bus.out_data), 0);
    check(bus.out_xcoord == 0, "rst_out_xcoord", 64'(bus.out_xcoord), 0);
    check(bus.out_ycoord == 0, "rst_out_ycoord", 64'(bus.out_ycoord), 0);
    check(bus.out_last == 0,   "rst_out_last",   64'(bus.out_last), 0);
    check(busy == 0,           "rst_busy",       64'(busy), 0);
    check(frame_done == 0,     "rst_frame_done", 64'(frame_done), 0);
    check(overrun == 0,        "rst_overrun",    64'(overrun), 0);

    // Latency and full-frame timing at full throughput.
    ready_mode = 0;
    do_reset();
    push_frame();
    @(posedge clock); #1 buffer_full = 1;
    @(posedge clock); #1 buffer_full = 0;
    first_c = 0; last_c = 0; done_c = 0;
    for (int c = 1; c <= 130; c++) begin
      @(negedge clock);
      if (c == 1) begin
        check(bus.rd_en == 1,   "t1_rd_en",   64'(bus.rd_en), 1);
        check(bus.rd_addr == 0, "t1_rd_addr", 64'(bus.rd_addr), 0);
        check(busy == 1,        "t1_busy",    64'(busy), 1);
      end
      if (bus.out_valid && first_c == 0) first_c = c;
      if (bus.out_valid && bus.out_ready && bus.out_last) last_c = c;
      if (frame_done && done_c == 0) done_c = c;
      if (c == 123) check(busy == 1, "busy_at_last", 64'(busy), 1);
      if (c == 124) check(busy == 0, "busy_after_last", 64'(busy), 0);
    end
    check(first_c == 3,   "first_valid_cycle", 64'(first_c), 3);
    check(last_c == 123,  "last_beat_cycle",   64'(last_c), 123);
    check(done_c == 124,  "frame_done_cycle",  64'(done_c), 124);
    check(frames_done == 1 && q.size() == 0, "timing_frame_count", 64'(frames_done), 1);

    for (int s = 0; s < 6; s++) begin
      do_reset();
      ready_mode = sc[s].ready_mode;
      for (int f = 0; f < sc[s].exp_frames; f++) push_frame();
      @(posedge clock); #1 buffer_full = 1;
      repeat (sc[s].hold) @(posedge clock);
      #1 buffer_full = 0;
      if (sc[s].extra > 0) begin
        repeat (20) @(posedge clock);
        for (int e = 0; e < sc[s].extra; e++) begin
          #1 buffer_full = 1;
          @(posedge clock);
          #1 buffer_full = 0;
          @(posedge clock);
        end
      end
      wait_frames(sc[s].exp_frames, 6000);
      repeat (20) @(negedge clock);
      check(frames_done == sc[s].exp_frames, $sformatf("scen%0d_frames", s), 64'(frames_done), 64'(sc[s].exp_frames));
      check(q.size() == 0, $sformatf("scen%0d_leftover", s), 64'(q.size()), 0);
      check(overrun == sc[s].exp_overrun, $sformatf("scen%0d_overrun", s), 64'(overrun), 64'(sc[s].exp_overrun));
      check(busy == 0, $sformatf("scen%0d_idle", s), 64'(busy), 0);
    end

    // Asynchronous reset in the middle of a frame, then restart.
    ready_mode = 0;
    do_reset();
    push_frame();
    @(posedge clock); #1 buffer_full = 1;
    @(posedge clock); #1 buffer_full = 0;
    begin
      int cyc = 0;
      while (xfers_tot < 50 && cyc < 500) begin
        @(negedge clock);
        cyc++;
      end
      check(cyc < 500, "mid_wait_budget", 64'(cyc), 500);
    end
    #1 reset = 1;
    #1;
    check(bus.out_valid == 0, "mid_rst_out_valid", 64'(bus.out_valid), 0);
    check(bus.rd_en == 0,     "mid_rst_rd_en",     64'(bus.rd_en), 0);
    check(bus.rd_addr == 0,   "mid_rst_rd_addr",   64'(bus.rd_addr), 0);
    check(bus.out_data == 0 && bus.out_xcoord == 0 && bus.out_ycoord == 0 && bus.out_last == 0,
          "mid_rst_out_fields", 64'({bus.out_last, bus.out_ycoord, bus.out_xcoord, bus.out_data}), 0);
    check(busy == 0,          "mid_rst_busy",      64'(busy), 0);
    flush();
    repeat (2) @(posedge clock);
    #1 reset = 0;
    flush();
    push_frame();
    @(posedge clock); #1 buffer_full = 1;
    @(posedge clock); #1 buffer_full = 0;
    wait_frames(1, 1000);
    repeat (10) @(negedge clock);
    check(frames_done == 1, "restart_frames", 64'(frames_done), 1);
    check(q.size() == 0, "restart_leftover", 64'(q.size()), 0);
    check(overrun == 0, "restart_overrun", 64'(overrun), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
